// File: rtl/multi_mode_counter.sv
// Multi-mode counter: binary up/down, ring and Johnson sequences with load, reseed on mode change.
// Optional build macro MULTI_MODE_COUNTER_SAT_EN makes the binary modes saturate instead of wrap.
module multi_mode_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] d,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_UP      = 2'b00,
        MODE_DOWN    = 2'b01,
        MODE_RING    = 2'b10,
        MODE_JOHNSON = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LOW_MASK = {1'b0, {(WIDTH-1){1'b1}}};

    mode_e            w_mode;
    mode_e            r_mode_q;
    logic [WIDTH-1:0] r_d;
    logic             w_mode_change;
    logic [WIDTH-1:0] w_seed;
    logic [WIDTH-1:0] w_terminal;
    logic [WIDTH-1:0] w_step;
    logic             w_ring_legal;
    logic [WIDTH-1:0] w_john_trans;
    logic             w_john_legal;

    assign w_mode        = mode_e'(mode);
    assign w_mode_change = (w_mode != r_mode_q);

    // Legal ring code is exactly one-hot; legal Johnson code has at most one 0/1 boundary.
    assign w_ring_legal  = (r_d != ALL_ZERO) && ((r_d & (r_d - ONE)) == ALL_ZERO);
    assign w_john_trans  = (r_d ^ (r_d >> 1)) & LOW_MASK;
    assign w_john_legal  = ((w_john_trans & (w_john_trans - ONE)) == ALL_ZERO);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_seed     = ALL_ZERO;
        w_terminal = ALL_ONES;
        w_step     = r_d;
        case (w_mode)
            MODE_UP: begin
                w_seed     = ALL_ZERO;
                w_terminal = ALL_ONES;
`ifdef MULTI_MODE_COUNTER_SAT_EN
                w_step     = (r_d == ALL_ONES) ? r_d : r_d + ONE;
`else
                w_step     = r_d + ONE;
`endif
            end
            MODE_DOWN: begin
                w_seed     = ALL_ONES;
                w_terminal = ALL_ZERO;
`ifdef MULTI_MODE_COUNTER_SAT_EN
                w_step     = (r_d == ALL_ZERO) ? r_d : r_d - ONE;
`else
                w_step     = r_d - ONE;
`endif
            end
            MODE_RING: begin
                w_seed     = ONE;
                w_terminal = MSB_ONLY;
                w_step     = w_ring_legal ? {r_d[WIDTH-2:0], r_d[WIDTH-1]} : ONE;
            end
            MODE_JOHNSON: begin
                w_seed     = ALL_ZERO;
                w_terminal = MSB_ONLY;
                w_step     = w_john_legal ? {r_d[WIDTH-2:0], ~r_d[WIDTH-1]} : ALL_ZERO;
            end
            default: begin
                w_seed     = ALL_ZERO;
                w_terminal = ALL_ONES;
                w_step     = r_d;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d      <= ALL_ZERO;
            r_mode_q <= MODE_UP;
        end else begin
            r_mode_q <= w_mode;
            if (load) begin
                r_d <= load_val;
            end else if (w_mode_change) begin
                r_d <= w_seed;
            end else if (en) begin
                r_d <= w_step;
            end
        end
    end

    assign d  = r_d;
    // Suppressed while reset, load or a reseed is pending, since the next value is not a step.
    assign tc = rst & en & ~load & ~w_mode_change & (r_d == w_terminal);

endmodule

// File: tb/tb_multi_mode_counter.sv
// Directed self-checking bench for multi_mode_counter at WIDTH=5.
// Binary wrap vs saturation expectations follow MULTI_MODE_COUNTER_SAT_EN.
module tb_multi_mode_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [4:0] load_val;
    logic [4:0] d;
    logic       tc;

    int n_checks = 0;
    int n_errors = 0;

    multi_mode_counter #(.WIDTH(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .d        (d),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic [4:0] ring_seq [5];
        logic [4:0] john_seq [10];
        ring_seq = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        john_seq = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111,
                     5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000};

        rst = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = 5'd0;
        #3;
        check("reset_d", 32'(d), 0);
        check("reset_tc", 32'(tc), 0);
        en = 1'b1; mode = 2'b01;
        #1;
        check("reset_tc_mode01", 32'(tc), 0);

        // Binary up through a full wrap.
        tick();
        mode = 2'b00; en = 1'b1;
        #2 rst = 1'b1;
        for (int i = 0; i < 33; i++) begin
            tick();
            check("up_d", 32'(d), 32'((i + 1) % 32));
            check("up_tc", 32'(tc), 32'(((i + 1) % 32) == 31));
        end

        // Reach 5, then switch to down.
        for (int i = 0; i < 4; i++) tick();
        check("up_to5", 32'(d), 5);
        mode = 2'b01;
        #1;
        check("down_pending_tc", 32'(tc), 0);
        tick();
        check("down_reseed", 32'(d), 31);
        tick();
        check("down_30", 32'(d), 30);
        tick();
        check("down_29", 32'(d), 29);
        for (int i = 28; i >= 0; i--) begin
            tick();
            check("down_d", 32'(d), 32'(i));
            check("down_tc", 32'(tc), 32'(i == 0));
        end
        tick();
        check("down_wrap", 32'(d), 31);
        en = 1'b0;
        tick();
        check("hold_d", 32'(d), 31);

        // Ring.
        mode = 2'b10; en = 1'b1;
        #1;
        check("ring_pending_tc", 32'(tc), 0);
        tick();
        check("ring_seed", 32'(d), 5'b00001);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ring_d", 32'(d), 32'(ring_seq[i]));
            check("ring_tc", 32'(tc), 32'(ring_seq[i] == 5'b10000));
            if (ring_seq[i] == 5'b10000) begin
                en = 1'b0;
                #1;
                check("ring_tc_en0", 32'(tc), 0);
                en = 1'b1;
                #1;
                check("ring_tc_en1", 32'(tc), 1);
            end
        end
        en = 1'b0; load = 1'b1; load_val = 5'b00110;
        #1;
        check("load_tc", 32'(tc), 0);
        tick();
        check("ring_load", 32'(d), 5'b00110);
        load = 1'b0; en = 1'b1;
        tick();
        check("ring_correct_multi", 32'(d), 5'b00001);

        // Johnson.
        mode = 2'b11;
        tick();
        check("john_seed", 32'(d), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("john_d", 32'(d), 32'(john_seq[i]));
            check("john_tc", 32'(tc), 32'(john_seq[i] == 5'b10000));
        end
        en = 1'b0; load = 1'b1; load_val = 5'b00101;
        tick();
        check("john_load", 32'(d), 5'b00101);
        load = 1'b0; en = 1'b1;
        tick();
        check("john_correct", 32'(d), 0);

        // Load beats a simultaneous mode change and enable.
        mode = 2'b00; load = 1'b1; load_val = 5'b01010; en = 1'b1;
        #1;
        check("load_mc_tc", 32'(tc), 0);
        tick();
        check("load_mc_d", 32'(d), 5'b01010);
        load_val = 5'd31;
        tick();
        check("load31_d", 32'(d), 31);
        check("load31_tc_masked", 32'(tc), 0);
        load = 1'b0;
        #1;
        check("load31_tc", 32'(tc), 1);
        tick();
        check("up_wrap_after_load", 32'(d), 0);
        for (int i = 1; i <= 3; i++) tick();
        check("pre_reset_d", 32'(d), 3);

        // Mid-count asynchronous reset.
        #2 rst = 1'b0;
        #1;
        check("async_rst_d", 32'(d), 0);
        check("async_rst_tc", 32'(tc), 0);
        mode = 2'b01;
        tick();
        check("rst_hold_d", 32'(d), 0);
        rst = 1'b1;
        #1;
        check("release_pending_tc", 32'(tc), 0);
        tick();
        check("release_mode01_reseed", 32'(d), 31);
        rst = 1'b0; mode = 2'b00;
        #2 rst = 1'b1;
        tick();
        check("release_mode00_first", 32'(d), 1);

        // Ring correction from all-zero, via load alongside a mode change.
        mode = 2'b10; load = 1'b1; load_val = 5'b00000;
        tick();
        check("ring_load_zero", 32'(d), 0);
        load = 1'b0;
        tick();
        check("ring_correct_zero", 32'(d), 5'b00001);

        // Binary terminal behaviour: saturate or wrap depending on build.
        mode = 2'b00; load = 1'b1; load_val = 5'd30;
        tick();
        load = 1'b0;
        check("bin_load30", 32'(d), 30);
`ifdef MULTI_MODE_COUNTER_SAT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_up_d", 32'(d), 31);
            check("sat_up_tc", 32'(tc), 1);
        end
        mode = 2'b01; load = 1'b1; load_val = 5'd1;
        tick();
        load = 1'b0;
        tick();
        check("sat_dn_0", 32'(d), 0);
        check("sat_dn_tc", 32'(tc), 1);
        tick();
        check("sat_dn_hold", 32'(d), 0);
`else
        tick();
        check("wrap_up_31", 32'(d), 31);
        tick();
        check("wrap_up_0", 32'(d), 0);
        mode = 2'b01; load = 1'b1; load_val = 5'd1;
        tick();
        load = 1'b0;
        tick();
        check("wrap_dn_0", 32'(d), 0);
        tick();
        check("wrap_dn_31", 32'(d), 31);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_mode_counter.md
MULTI_MODE_COUNTER -- requirements
Module: multi_mode_counter

Interface
REQ-001 Parameter WIDTH, default 5, counter width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  count enable; 0 holds d.
REQ-005 mode  input  2  00 binary up, 01 binary down, 10 ring (one-hot rotate left), 11 Johnson (twisted ring, shift left, inverted MSB into LSB).
REQ-006 load  input  1  synchronous parallel load strobe.
REQ-007 load_val  input  WIDTH  value taken on load.
REQ-008 d  output  WIDTH  registered counter value.
REQ-009 tc  output  1  terminal-count flag, combinational from d, mode and en.

Function
REQ-010 Per-mode seed: up 0, down all-ones, ring 1 (bit 0 set), Johnson 0.
REQ-011 Per-mode terminal value: up all-ones, down 0, ring MSB-only, Johnson MSB-only (e.g. 10000 for WIDTH=5).
REQ-012 Block registers the previous mode (mode_q); a mode change is mode != mode_q at a rising edge.
REQ-013 Next-state priority, highest first: load -> d=load_val; mode change -> d=seed of new mode; en=1 -> one step of current mode; else hold.
REQ-014 Mode change reseeds regardless of en; mode_q updates every cycle out of reset.
REQ-015 Up: d+1 modulo 2^WIDTH; down: d-1 modulo 2^WIDTH (wrap all-ones->0 and 0->all-ones).
REQ-016 Ring: d rotates left by one; MSB wraps into bit 0; period WIDTH.
REQ-017 Ring self-correction: when en=1, mode=10 and d not exactly one-hot (zero or multiple bits), next d = 1.
REQ-018 Johnson: d = {d[WIDTH-2:0], ~d[WIDTH-1]}; period 2*WIDTH from seed.
REQ-019 Johnson self-correction: when en=1, mode=11 and d not a legal Johnson code, next d = 0.
REQ-020 tc = en AND (d == terminal value of current mode); the next enabled step wraps.
REQ-021 tc = 0 whenever load=1 or a mode change is pending.
REQ-022 load with en=0 still loads; loaded value is used unchanged (correction applies only on the following enabled step).

Reset
REQ-023 rst=0 forces, without waiting for clk: d=0, mode_q=00, tc=0.
REQ-024 Reset asserted mid-count discards progress; first edge after release with en=1, mode=00 gives d=1.
REQ-025 If mode!=00 at reset release, the first edge performs a mode-change reseed per REQ-013.

Configuration
REQ-026 Macro MULTI_MODE_COUNTER_SAT_EN: when defined, binary modes saturate (up holds at all-ones, down holds at 0) and tc stays high while at terminal with en=1; ring/Johnson unaffected.
REQ-027 Without MULTI_MODE_COUNTER_SAT_EN, binary modes wrap per REQ-015.

Verification (WIDTH=5)
REQ-028 Reset, mode=00, en=1 for 33 edges -> d 0,1,...,31,0,1; tc high only while d=31.
REQ-029 From d=5 in mode 00, set mode=01 -> next edge d=31, then 30,29; at d=0 tc=1, next edge d=31.
REQ-030 mode=10 after reseed -> d 00001,00010,00100,01000,10000,00001; tc=1 at 10000; load 00110 then en -> d=00001.
REQ-031 mode=11 -> 00000,00001,00011,00111,01111,11111,11110,11100,11000,10000,00000; load 00101 then en -> d=00000.
REQ-032 load=1 (load_val=01010) in same cycle as mode change and en=1 -> d=01010, tc=0; rst low mid-count -> d=0 immediately, before next clk edge.
REQ-033 With MULTI_MODE_COUNTER_SAT_EN defined: up from 30 -> 31,31,31 with tc=1; down from 1 -> 0,0.
